cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Clock-sequencing controller for the CPU core. It replaces the free-running debounced step clock with a single-clock-domain clock-enable generator. The raw push button and a run switch are synchronized and debounced, and the block issues one-cycle `cpu_ce` pulses in single-step or free-run mode. It stops on a halt request from the CPU and keeps an 8-bit count of issued steps for the seven-segment display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 5000: consecutive stable cycles required before the debounced button level changes (≥2).
- `RUN_DIV`, default 1000000: clock cycles per `cpu_ce` pulse in run mode (≥2).

Ports (one clock; `reset` is asynchronous and active-high):
- `clk` in 1: system clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `button` in 1: raw, bouncy push button, asynchronous to `clk`.
- `run_sw` in 1: raw switch, asynchronous; 1 = free-run, 0 = single-step.
- `halt_req` in 1: synchronous level from the CPU; 1 = stop issuing enables.
- `cpu_ce` out 1: registered one-cycle clock-enable to the CPU pipeline.
- `ticks` out 8: number of `cpu_ce` pulses issued, modulo 256.
- `state` out 2: FSM state; IDLE=00, STEP=01, RUN=10, HALTED=11.
- `press` out 1: registered one-cycle debounced press event, for debug.

## Operation

- **Synchronizers:** `button` and `run_sw` each pass through two flops, giving `btn_s` and `run_s`. Both reset to 0.
- **Debounce:**
  - Counter `db_cnt` and level `db_lvl`, both reset to 0.
  - If `btn_s == db_lvl`, then `db_cnt` ← 0.
  - Otherwise `db_cnt` increments. When it reaches `DEBOUNCE_CYCLES-1`, `db_lvl` ← `btn_s` and `db_cnt` ← 0.
  - The level therefore changes only after `DEBOUNCE_CYCLES` consecutive differing samples.
- **Press:** `press` ← `db_lvl & ~db_lvl_q`, a registered rising-edge pulse. Holding the button gives exactly one event; release gives none.
- **FSM.** Priority within each state is top to bottom.
  - IDLE:
    - `halt_req` → HALTED.
    - `run_s` → RUN.
    - `press` → STEP.
    - Otherwise stay.
  - STEP: lasts exactly one cycle.
    - `halt_req` → HALTED.
    - Otherwise → IDLE.
  - RUN:
    - `halt_req` → HALTED.
    - `!run_s` → IDLE.
    - Otherwise stay. Press events are ignored.
  - HALTED:
    - `press` with `!halt_req` → IDLE.
    - Otherwise stay.
    - `run_s` alone never leaves HALTED.
- **`cpu_ce`:** a register, updated at the same edge as `state`.
  - It is 1 for the cycle in which `state==STEP`.
  - In RUN it is 1 for the one cycle after `div_cnt` wraps.
  - It is 0 in IDLE and HALTED.
- **`div_cnt`:**
  - Counts 0..`RUN_DIV-1` only while in RUN; at `RUN_DIV-1` it wraps to 0 and `cpu_ce` is set.
  - It is cleared on any transition into RUN, so the first run pulse comes `RUN_DIV` cycles after entry.
  - It is also cleared whenever the FSM is outside RUN.
- **`halt_req` gating:** when `halt_req` is sampled high, `cpu_ce` is forced 0 at that edge, even if a wrap or STEP entry coincides. A halt raised by an instruction therefore gets no further enables.
- **`ticks`:** increments by 1 at the edge after each `cpu_ce` cycle, wrapping 255 → 0.
- **Mid-operation reset:** any `reset` assertion immediately forces the following:
  - `state` = IDLE.
  - `cpu_ce`, `press` and `ticks` = 0.
  - Synchronizers, `db_lvl`, `db_cnt` and `div_cnt` = 0.

## Timing

- **Reset values:** `cpu_ce`=0, `ticks`=0x00, `state`=00, `press`=0.
- **Step latency:** counting the first rising edge that samples `button`=1 as edge 0:
  - `db_lvl` rises at edge D+1, where D = `DEBOUNCE_CYCLES`.
  - `press` is high in the cycle after edge D+2.
  - `state`=STEP and `cpu_ce`=1 in the cycle after edge D+3, for exactly one cycle.
- **Glitches:** any button high or low excursion shorter than D synchronized cycles has no effect.
- **Run mode:** entry to RUN occurs 1 edge after `run_s` is high in IDLE. Pulses are spaced exactly `RUN_DIV` cycles apart; duty is 1/`RUN_DIV`.
- **Halt:** `halt_req` high at edge N gives `state`=HALTED and `cpu_ce`=0 after edge N.
- **Step count:** one press gives exactly one pulse, with no double stepping.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `RUN_DIV`=3.
- **Clean press:** raise `button` and hold it 20 cycles.
  - Expect exactly one `cpu_ce` pulse, 7 edges after the first sampling edge; then `ticks`=1 and `state` back to 00.
- **Bounce:** toggle `button` 1,0,1,0 one cycle each, then hold 1.
  - Expect no event until 4 stable cycles, then exactly one `cpu_ce`; `ticks`=1.
- **Run mode:** set `run_sw`=1 for 30 cycles, then 0.
  - Expect `state`=10 and `cpu_ce` every 3rd cycle, the first 3 cycles after entry.
  - After `run_sw` clears (plus sync delay), `state`=00 and no further pulses.
- **Halt during run:** assert `halt_req` on the same edge `div_cnt` wraps.
  - Expect `cpu_ce` to stay 0 and `state`=11.
  - Pressing with `halt_req` still 1 keeps 11; deasserting `halt_req` then pressing gives 00 and no pulse.
- **Wrap and reset:** issue 256 steps.
  - Expect `ticks`=0x00 after the 256th step.
  - Asserting `reset` mid-run (asynchronous, between edges) forces `cpu_ce`=0, `state`=00, `ticks`=0 immediately.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the CPU core: synchronizes and debounces the step
// button and run switch, then issues single-step or free-run cpu_ce pulses.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int RUN_DIV         = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic       run_sw,
    input  logic       halt_req,
    output logic       cpu_ce,
    output logic [7:0] ticks,
    output logic [1:0] state,
    output logic       press
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_ZERO  = DB_W'(0);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STEP   = 2'b01,
        RUN    = 2'b10,
        HALTED = 2'b11
    } state_t;

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic             run_meta_r;
    logic             run_sync_r;
    logic [DB_W-1:0]  db_cnt_r;
    logic             db_lvl_r;
    logic             db_lvl_q_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_nxt_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             ce_nxt_s;

    // Two-flop synchronizers for the asynchronous button and run switch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            run_meta_r <= 1'b0;
            run_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= button;
            btn_sync_r <= btn_meta_r;
            run_meta_r <= run_sw;
            run_sync_r <= run_meta_r;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r <= DB_ZERO;
            db_lvl_r <= 1'b0;
        end else if (btn_sync_r == db_lvl_r) begin
            db_cnt_r <= DB_ZERO;
        end else if (db_cnt_r == DB_MAX) begin
            db_lvl_r <= btn_sync_r;
            db_cnt_r <= DB_ZERO;
        end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
        end
    end

    // Registered rising-edge detector on the debounced level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_lvl_q_r <= 1'b0;
            press      <= 1'b0;
        end else begin
            db_lvl_q_r <= db_lvl_r;
            press      <= db_lvl_r & ~db_lvl_q_r;
        end
    end

    // Next-state, divider and enable logic; halt_req outranks every enable source
    always_comb begin
        state_nxt_s   = state_r;
        ce_nxt_s      = 1'b0;
        div_cnt_nxt_s = DIV_ZERO;
        case (state_r)
            IDLE: begin
                if (halt_req) begin
                    state_nxt_s = HALTED;
                end else if (run_sync_r) begin
                    state_nxt_s = RUN;
                end else if (press) begin
                    state_nxt_s = STEP;
                    ce_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STEP: begin
                if (halt_req) begin
                    state_nxt_s = HALTED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nxt_s = HALTED;
                end else if (!run_sync_r) begin
                    state_nxt_s = IDLE;
                end else if (div_cnt_r == DIV_MAX) begin
                    state_nxt_s   = RUN;
                    ce_nxt_s      = 1'b1;
                    div_cnt_nxt_s = DIV_ZERO;
                end else begin
                    state_nxt_s   = RUN;
                    div_cnt_nxt_s = div_cnt_r + DIV_ONE;
                end
            end
            HALTED: begin
                if (press && !halt_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, divider, enable and step counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            div_cnt_r <= DIV_ZERO;
            cpu_ce    <= 1'b0;
            ticks     <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            div_cnt_r <= div_cnt_nxt_s;
            cpu_ce    <= ce_nxt_s;
            ticks     <= ticks + {7'd0, cpu_ce};
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomized and directed bench for cpu_step_ctrl against a behavioural model.
module tb_cpu_step_ctrl;

    localparam int D  = 4;
    localparam int RD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       button;
    logic       run_sw;
    logic       halt_req;
    logic       cpu_ce;
    logic [7:0] ticks;
    logic [1:0] state;
    logic       press;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ce_seen  = 0;
    int first_ce = -1;

    // Behavioural model state (states use the external encoding 0..3)
    int m_bq1, m_bs, m_rq1, m_rs, m_lvl, m_lvlq, m_run_len, m_press;
    int m_st, m_ce, m_ticks, m_age;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .run_sw   (run_sw),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .ticks    (ticks),
        .state    (state),
        .press    (press)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bq1 = 0; m_bs = 0; m_rq1 = 0; m_rs = 0;
        m_lvl = 0; m_lvlq = 0; m_run_len = 0; m_press = 0;
        m_st = 0; m_ce = 0; m_ticks = 0; m_age = 0;
    endtask

    // One rising edge of the model; every right-hand side reads pre-edge values
    task automatic model_step();
        int n_st;
        int n_ce;
        n_ce = 0;
        case (m_st)
            0:       n_st = halt_req ? 3 : (m_rs != 0) ? 2 : (m_press != 0) ? 1 : 0;
            1:       n_st = halt_req ? 3 : 0;
            2:       n_st = halt_req ? 3 : (m_rs == 0) ? 0 : 2;
            default: n_st = ((m_press != 0) && !halt_req) ? 0 : 3;
        endcase
        if (!halt_req) begin
            if (n_st == 1) n_ce = 1;
            else if (m_st == 2 && n_st == 2 && ((m_age + 1) % RD) == 0) n_ce = 1;
        end
        m_age   = (m_st == 2 && n_st == 2) ? m_age + 1 : 0;
        m_ticks = (m_ticks + m_ce) % 256;
        m_st    = n_st;
        m_ce    = n_ce;
        m_press = (m_lvl != 0 && m_lvlq == 0) ? 1 : 0;
        m_lvlq  = m_lvl;
        if (m_bs != m_lvl) begin
            m_run_len++;
            if (m_run_len == D) begin
                m_lvl     = m_bs;
                m_run_len = 0;
            end
        end else begin
            m_run_len = 0;
        end
        m_bs  = m_bq1;
        m_bq1 = int'(button);
        m_rs  = m_rq1;
        m_rq1 = int'(run_sw);
    endtask

    task automatic cycle(input logic b, input logic r, input logic h);
        button   = b;
        run_sw   = r;
        halt_req = h;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_eq("cpu_ce", {31'd0, cpu_ce}, m_ce);
        check_eq("state", {30'd0, state}, m_st);
        check_eq("ticks", {24'd0, ticks}, m_ticks);
        check_eq("press", {31'd0, press}, m_press);
        if (cpu_ce) begin
            ce_seen++;
            if (first_ce < 0) first_ce = cyc;
        end
    endtask

    // Assert reset between edges and confirm outputs clear without a clock edge
    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_eq({tag, "_ce"}, {31'd0, cpu_ce}, 32'd0);
        check_eq({tag, "_state"}, {30'd0, state}, 32'd0);
        check_eq({tag, "_ticks"}, {24'd0, ticks}, 32'd0);
        check_eq({tag, "_press"}, {31'd0, press}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        int ce0;
        int bl, rl, hl;
        logic b, r, h;
        logic aligned;

        reset = 1'b1; button = 1'b0; run_sw = 1'b0; halt_req = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ce", {31'd0, cpu_ce}, 32'd0);
        check_eq("rst_state", {30'd0, state}, 32'd0);
        check_eq("rst_ticks", {24'd0, ticks}, 32'd0);
        check_eq("rst_press", {31'd0, press}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Clean press: one pulse, 7 edges after the first sampling edge
        t0 = cyc + 1; first_ce = -1; ce0 = ce_seen;
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        check_eq("clean_latency", first_ce - t0, 32'd7);
        check_eq("clean_count", ce_seen - ce0, 32'd1);
        check_eq("clean_ticks", {24'd0, ticks}, 32'd1);
        check_eq("clean_state", {30'd0, state}, 32'd0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Bounce: short excursions ignored, one pulse once the level holds
        ce0 = ce_seen;
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
        repeat (15) cycle(1'b1, 1'b0, 1'b0);
        check_eq("bounce_count", ce_seen - ce0, 32'd1);
        check_eq("bounce_ticks", {24'd0, ticks}, 32'd2);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Run mode: 30 cycles of run_sw gives 9 pulses, then back to IDLE
        ce0 = ce_seen;
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        check_eq("run_state", {30'd0, state}, 32'd2);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        check_eq("run_count", ce_seen - ce0, 32'd9);
        check_eq("run_exit_state", {30'd0, state}, 32'd0);

        // Halt coinciding with a divider wrap
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        aligned = 1'b0;
        for (int i = 0; i < 10 && !aligned; i++) begin
            if (m_st == 2 && ((m_age + 1) % RD) == 0) aligned = 1'b1;
            else cycle(1'b0, 1'b1, 1'b0);
        end
        check_eq("halt_align", {31'd0, aligned}, 32'd1);
        ce0 = ce_seen;
        cycle(1'b0, 1'b1, 1'b1);
        check_eq("halt_ce", {31'd0, cpu_ce}, 32'd0);
        check_eq("halt_state", {30'd0, state}, 32'd3);
        repeat (12) cycle(1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 1'b1);
        check_eq("halt_press_held", {30'd0, state}, 32'd3);
        repeat (12) cycle(1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0);
        check_eq("halt_release_state", {30'd0, state}, 32'd0);
        check_eq("halt_no_pulse", ce_seen - ce0, 32'd0);

        // Randomized inputs held for random durations
        bl = 0; rl = 0; hl = 0; b = 1'b0; r = 1'b0; h = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (bl == 0) begin b = 1'($urandom_range(0, 1)); bl = $urandom_range(1, 9); end
            if (rl == 0) begin r = ($urandom_range(0, 3) == 0); rl = $urandom_range(1, 25); end
            if (hl == 0) begin h = ($urandom_range(0, 5) == 0); hl = $urandom_range(1, 12); end
            bl--; rl--; hl--;
            cycle(b, r, h);
        end

        // 256 single steps wrap the counter back to zero
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        async_reset_check("reset_pre_wrap");
        ce0 = ce_seen;
        repeat (256) begin
            repeat (9) cycle(1'b1, 1'b0, 1'b0);
            repeat (9) cycle(1'b0, 1'b0, 1'b0);
        end
        check_eq("wrap_count", ce_seen - ce0, 32'd256);
        check_eq("wrap_ticks", {24'd0, ticks}, 32'd0);

        // Reset in the middle of free-run
        repeat (12) cycle(1'b0, 1'b1, 1'b0);
        check_eq("midrun_state", {30'd0, state}, 32'd2);
        async_reset_check("reset_midrun");
        repeat (8) cycle(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
